nts_engine_ctrl: RTL and testbench
==================================

# nts_engine_ctrl

Parametrised control FSM for the NTS engine; it replaces the fixed debug delay with a real parser handshake. It sequences packet intake from the dispatcher into the receive buffer, starts the parser, and bounds parse time with a programmable watchdog. It classifies each packet as processed, bad, overflowed or timed-out, and keeps saturating statistics. It sits between the dispatcher/rx buffer/parser and the engine API.

## Interface
- TIMEOUT_WIDTH, 16, width of the watchdog limit and timer
- COUNTER_WIDTH, 32, width of each statistics counter
- i_clk  in  1  clock
- i_areset  in  1  reset, asynchronous, active-high
- i_dispatch_packet_available  in  1  dispatcher holds a complete packet
- i_dispatch_fifo_empty  in  1  dispatcher FIFO empty
- i_buffer_overflow  in  1  rx buffer wrote past its depth (level)
- i_parser_done  in  1  parser finished without error (pulse)
- i_parser_error  in  1  parser rejected packet (pulse)
- i_timeout_cycles  in  TIMEOUT_WIDTH  parse limit in cycles; 0 = watchdog disabled
- i_clear_stats  in  1  synchronous zeroing of all counters
- o_clear  out  1  clear to rx buffer and parser
- o_parser_start  out  1  one-cycle parse start pulse
- o_dispatch_packet_read_discard  out  1  one-cycle release of dispatcher packet
- o_busy  out  1  packet in flight
- o_state  out  4  current state code (debug)
- o_cnt_processed, o_cnt_bad, o_cnt_overflow, o_cnt_timeout  out  COUNTER_WIDTH each  saturating event counters

## Operation
- State codes: RESET 0x0, EMPTY 0x1, COPY 0x2, PROCESS 0x3, DONE 0x4, ERR_BAD 0xC, ERR_OVERFLOW 0xD, ERR_TIMEOUT 0xE. Any other code moves to RESET with busy cleared.
- RESET: o_clear=1; discard and busy are written 0 at the next edge; next state EMPTY.
- EMPTY: if available && !fifo_empty, go to COPY and set busy.
- COPY: overflow has priority and goes to ERR_OVERFLOW. Otherwise, when fifo_empty, go to PROCESS, set the start register and zero the timer.
- PROCESS: timer increments each cycle.
  - Error goes to ERR_BAD. Error wins over a coincident done.
  - Otherwise done goes to DONE. Done wins over a coincident timeout.
  - Otherwise, if i_timeout_cycles≠0 and timer == i_timeout_cycles−1, go to ERR_TIMEOUT.
  - i_buffer_overflow is ignored in PROCESS.
- DONE and each ERR_* state: last for one cycle. At the exit edge they set the discard register, clear busy, and increment their counter (DONE→processed, ERR_BAD→bad, ERR_OVERFLOW→overflow, ERR_TIMEOUT→timeout). Next state RESET.
- Counters saturate at all-ones. i_clear_stats zeroes all counters and wins over a coincident increment.
- Reset mid-operation: all registers return to reset values immediately. No discard is issued for the aborted packet.

## Timing
- Reset values: state RESET, o_clear 1, o_parser_start 0, discard 0, o_busy 0, all counters 0, timer 0.
- All outputs except o_clear and o_state are registered. o_clear is decoded from state == RESET.
- o_parser_start is high exactly the first PROCESS cycle.
- o_dispatch_packet_read_discard is high exactly one cycle, coincident with the RESET cycle after DONE/ERR_*. o_busy falls on the same edge.
- The counter is visible updated in that same RESET cycle.
- Timeout N≥1: PROCESS occupies exactly N cycles and ERR_TIMEOUT follows. Done in PROCESS cycle k<N (cycle index 0 = first) gives DONE in cycle k+1.
- Minimum packet turnaround, EMPTY→EMPTY: EMPTY, COPY(≥1), PROCESS(≥1), DONE, RESET.

## Structure
- Shared package nts_engine_pkg: 4-bit state localparams, plus the 4-bit state width constant.
- Sub-module nts_sat_counter, parameter WIDTH, with ports i_clk, i_areset, i_clear, i_inc, o_count. Four instances, clear priority over increment.
- Top-level FSM, timer and output registers live in nts_engine_ctrl.

## Test plan
- Normal packet, timeout=100: available, FIFO drains 3 cycles later, done 5 cycles after start → start pulse 1 cycle, discard 1 cycle, busy low, processed=1, others 0.
- Overflow asserted during COPY together with fifo_empty → ERR_OVERFLOW, no parser_start, overflow=1, discard pulse.
- Timeout=4, no done → exactly 4 PROCESS cycles, ERR_TIMEOUT, timeout=1. Repeat with timeout=0 and done after 500 cycles → processed incremented, no timeout.
- Done and error in the same PROCESS cycle → bad=1, processed unchanged. Done on the timer==N−1 cycle → processed=1, timeout=0.
- COUNTER_WIDTH=2 with 5 processed packets → counter holds 3. i_clear_stats coincident with the 6th packet's increment → 0.
- i_areset asserted mid-PROCESS → o_state 0, busy 0, no discard pulse. Next packet is processed normally.

Source files
------------

// File: rtl/nts_engine_pkg.sv
// Shared definitions for the NTS engine control path.
// State codes are fixed so software reading o_state sees stable values.
package nts_engine_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET        = 4'h0,
        ST_EMPTY        = 4'h1,
        ST_COPY         = 4'h2,
        ST_PROCESS      = 4'h3,
        ST_DONE         = 4'h4,
        ST_ERR_BAD      = 4'hC,
        ST_ERR_OVERFLOW = 4'hD,
        ST_ERR_TIMEOUT  = 4'hE
    } state_e;

endpackage

// File: rtl/nts_sat_counter.sv
// Saturating event counter; a clear beats a coincident increment.
module nts_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_areset,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;

endmodule

// File: rtl/nts_engine_ctrl.sv
// NTS engine control FSM: dispatcher intake, parser handshake,
// parse watchdog and per-outcome saturating statistics.
module nts_engine_ctrl
    import nts_engine_pkg::*;
#(
    parameter int TIMEOUT_WIDTH = 16,
    parameter int COUNTER_WIDTH = 32
) (
    input  logic                     i_clk,
    input  logic                     i_areset,
    input  logic                     i_dispatch_packet_available,
    input  logic                     i_dispatch_fifo_empty,
    input  logic                     i_buffer_overflow,
    input  logic                     i_parser_done,
    input  logic                     i_parser_error,
    input  logic [TIMEOUT_WIDTH-1:0] i_timeout_cycles,
    input  logic                     i_clear_stats,
    output logic                     o_clear,
    output logic                     o_parser_start,
    output logic                     o_dispatch_packet_read_discard,
    output logic                     o_busy,
    output logic [STATE_W-1:0]       o_state,
    output logic [COUNTER_WIDTH-1:0] o_cnt_processed,
    output logic [COUNTER_WIDTH-1:0] o_cnt_bad,
    output logic [COUNTER_WIDTH-1:0] o_cnt_overflow,
    output logic [COUNTER_WIDTH-1:0] o_cnt_timeout
);

    state_e                   state_q, state_d;
    logic [TIMEOUT_WIDTH-1:0] timer_q, timer_d;
    logic                     start_q, start_d;
    logic                     discard_q, discard_d;
    logic                     busy_q, busy_d;
    logic                     inc_proc, inc_bad, inc_ovf, inc_tmo;
    logic                     wd_expired;

    // Watchdog fires on the last allowed PROCESS cycle; zero disables it.
    assign wd_expired = (i_timeout_cycles != '0) &&
        (timer_q == i_timeout_cycles - TIMEOUT_WIDTH'(1));

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        start_d   = 1'b0;
        discard_d = 1'b0;
        busy_d    = busy_q;
        inc_proc  = 1'b0;
        inc_bad   = 1'b0;
        inc_ovf   = 1'b0;
        inc_tmo   = 1'b0;
        case (state_q)
            ST_RESET: begin
                busy_d  = 1'b0;
                state_d = ST_EMPTY;
            end
            ST_EMPTY: begin
                if (i_dispatch_packet_available && !i_dispatch_fifo_empty) begin
                    busy_d  = 1'b1;
                    state_d = ST_COPY;
                end
            end
            ST_COPY: begin
                if (i_buffer_overflow) begin
                    state_d = ST_ERR_OVERFLOW;
                end else if (i_dispatch_fifo_empty) begin
                    start_d = 1'b1;
                    timer_d = '0;
                    state_d = ST_PROCESS;
                end
            end
            ST_PROCESS: begin
                timer_d = timer_q + TIMEOUT_WIDTH'(1);
                if (i_parser_error) begin
                    state_d = ST_ERR_BAD;
                end else if (i_parser_done) begin
                    state_d = ST_DONE;
                end else if (wd_expired) begin
                    state_d = ST_ERR_TIMEOUT;
                end
            end
            ST_DONE, ST_ERR_BAD, ST_ERR_OVERFLOW, ST_ERR_TIMEOUT: begin
                discard_d = 1'b1;
                busy_d    = 1'b0;
                inc_proc  = (state_q == ST_DONE);
                inc_bad   = (state_q == ST_ERR_BAD);
                inc_ovf   = (state_q == ST_ERR_OVERFLOW);
                inc_tmo   = (state_q == ST_ERR_TIMEOUT);
                state_d   = ST_RESET;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_RESET;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            state_q   <= ST_RESET;
            timer_q   <= '0;
            start_q   <= 1'b0;
            discard_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            start_q   <= start_d;
            discard_q <= discard_d;
            busy_q    <= busy_d;
        end
    end

    assign o_clear                        = (state_q == ST_RESET);
    assign o_parser_start                 = start_q;
    assign o_dispatch_packet_read_discard = discard_q;
    assign o_busy                         = busy_q;
    assign o_state                        = state_q;

    nts_sat_counter #(.WIDTH(COUNTER_WIDTH)) u_cnt_processed (
        .i_clk    (i_clk),
        .i_areset (i_areset),
        .i_clear  (i_clear_stats),
        .i_inc    (inc_proc),
        .o_count  (o_cnt_processed)
    );

    nts_sat_counter #(.WIDTH(COUNTER_WIDTH)) u_cnt_bad (
        .i_clk    (i_clk),
        .i_areset (i_areset),
        .i_clear  (i_clear_stats),
        .i_inc    (inc_bad),
        .o_count  (o_cnt_bad)
    );

    nts_sat_counter #(.WIDTH(COUNTER_WIDTH)) u_cnt_overflow (
        .i_clk    (i_clk),
        .i_areset (i_areset),
        .i_clear  (i_clear_stats),
        .i_inc    (inc_ovf),
        .o_count  (o_cnt_overflow)
    );

    nts_sat_counter #(.WIDTH(COUNTER_WIDTH)) u_cnt_timeout (
        .i_clk    (i_clk),
        .i_areset (i_areset),
        .i_clear  (i_clear_stats),
        .i_inc    (inc_tmo),
        .o_count  (o_cnt_timeout)
    );

endmodule

// File: tb/tb_nts_engine_ctrl.sv
// Directed bench for nts_engine_ctrl with 2-bit counters so
// saturation is reachable in a handful of packets.
module tb_nts_engine_ctrl;

    localparam int TW = 16;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          areset = 1'b1;
    logic          avail = 1'b0;
    logic          fempty = 1'b1;
    logic          ovf = 1'b0;
    logic          p_done = 1'b0;
    logic          p_err = 1'b0;
    logic [TW-1:0] tmo = '0;
    logic          clr = 1'b0;
    logic          o_clear, o_start, o_disc, o_busy;
    logic [3:0]    o_state;
    logic [CW-1:0] c_proc, c_bad, c_ovf, c_tmo;

    int tests = 0;
    int fails = 0;

    int         n_start, n_disc, n_proc, start_k;
    logic [3:0] term;
    logic       busy_at_disc, copy_busy, finished;
    logic [3:0] copy_state;

    nts_engine_ctrl #(.TIMEOUT_WIDTH(TW), .COUNTER_WIDTH(CW)) dut (
        .i_clk                          (clk),
        .i_areset                       (areset),
        .i_dispatch_packet_available    (avail),
        .i_dispatch_fifo_empty          (fempty),
        .i_buffer_overflow              (ovf),
        .i_parser_done                  (p_done),
        .i_parser_error                 (p_err),
        .i_timeout_cycles               (tmo),
        .i_clear_stats                  (clr),
        .o_clear                        (o_clear),
        .o_parser_start                 (o_start),
        .o_dispatch_packet_read_discard (o_disc),
        .o_busy                         (o_busy),
        .o_state                        (o_state),
        .o_cnt_processed                (c_proc),
        .o_cnt_bad                      (c_bad),
        .o_cnt_overflow                 (c_ovf),
        .o_cnt_timeout                  (c_tmo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    // Drives one packet and records what the DUT did; no checks here.
    task automatic run_pkt(input int copy_cyc, input bit with_ovf,
                           input int done_k, input int err_k,
                           input bit clr_on_term);
        int k;
        n_start = 0; n_disc = 0; n_proc = 0; start_k = -1;
        term = 4'h0; busy_at_disc = 1'b1; finished = 1'b0;
        for (int g = 0; g < 10 && o_state != 4'h1; g++) tick();
        avail = 1'b1;
        fempty = 1'b0;
        tick();
        copy_state = o_state;
        copy_busy = o_busy;
        avail = 1'b0;
        repeat (copy_cyc - 1) tick();
        fempty = 1'b1;
        ovf = with_ovf;
        k = 0;
        for (int g = 0; g < 2000; g++) begin
            tick();
            p_done = 1'b0;
            p_err = 1'b0;
            clr = 1'b0;
            if (o_state != 4'h2) ovf = 1'b0;
            if (o_start) begin
                n_start++;
                start_k = k;
            end
            if (o_disc) begin
                n_disc++;
                busy_at_disc = o_busy;
            end
            if (o_state == 4'h3) begin
                p_done = (k == done_k);
                p_err = (k == err_k);
                n_proc++;
                k++;
            end else if (o_state inside {4'h4, 4'hC, 4'hD, 4'hE}) begin
                term = o_state;
                clr = clr_on_term;
            end else if (o_state == 4'h1) begin
                finished = 1'b1;
                break;
            end
        end
        p_done = 1'b0;
        p_err = 1'b0;
        clr = 1'b0;
        ovf = 1'b0;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        tick();
        tests++;
        if ({o_state, o_clear, o_start, o_disc, o_busy} !== 8'b0000_1000) begin
            fails++;
            $display("FAIL reset_outputs: got state=%h clr=%b st=%b dis=%b busy=%b want 0 1 0 0 0",
                     o_state, o_clear, o_start, o_disc, o_busy);
        end
        tests++;
        if ({c_proc, c_bad, c_ovf, c_tmo} !== '0) begin
            fails++;
            $display("FAIL reset_counters: got %h %h %h %h want 0",
                     c_proc, c_bad, c_ovf, c_tmo);
        end
        areset = 1'b0;
        tick();
        tests++;
        if (o_state !== 4'h1 || o_clear !== 1'b0) begin
            fails++;
            $display("FAIL reset_to_empty: got state=%h clr=%b want 1 0", o_state, o_clear);
        end
    endtask

    task automatic test_normal();
        tmo = TW'(100);
        clear_stats();
        run_pkt(3, 1'b0, 5, -1, 1'b0);
        tests++;
        if (copy_state !== 4'h2 || copy_busy !== 1'b1) begin
            fails++;
            $display("FAIL normal_copy: got state=%h busy=%b want 2 1", copy_state, copy_busy);
        end
        tests++;
        if (n_start != 1 || start_k != 0) begin
            fails++;
            $display("FAIL normal_start: got n=%0d k=%0d want 1 0", n_start, start_k);
        end
        tests++;
        if (term !== 4'h4 || n_proc != 6 || !finished) begin
            fails++;
            $display("FAIL normal_flow: got term=%h proc=%0d fin=%b want 4 6 1",
                     term, n_proc, finished);
        end
        tests++;
        if (n_disc != 1 || busy_at_disc !== 1'b0 || o_busy !== 1'b0) begin
            fails++;
            $display("FAIL normal_discard: got n=%0d busy@dis=%b busy=%b want 1 0 0",
                     n_disc, busy_at_disc, o_busy);
        end
        tests++;
        if ({c_proc, c_bad, c_ovf, c_tmo} !== 8'b01_00_00_00) begin
            fails++;
            $display("FAIL normal_counts: got %0d %0d %0d %0d want 1 0 0 0",
                     c_proc, c_bad, c_ovf, c_tmo);
        end
    endtask

    task automatic test_overflow();
        clear_stats();
        run_pkt(2, 1'b1, -1, -1, 1'b0);
        tests++;
        if (term !== 4'hD || n_start != 0 || n_proc != 0) begin
            fails++;
            $display("FAIL ovf_flow: got term=%h start=%0d proc=%0d want D 0 0",
                     term, n_start, n_proc);
        end
        tests++;
        if (n_disc != 1 || {c_proc, c_bad, c_ovf, c_tmo} !== 8'b00_00_01_00) begin
            fails++;
            $display("FAIL ovf_counts: got dis=%0d %0d %0d %0d %0d want 1 0 0 1 0",
                     n_disc, c_proc, c_bad, c_ovf, c_tmo);
        end
    endtask

    task automatic test_timeout();
        clear_stats();
        tmo = TW'(4);
        run_pkt(1, 1'b0, -1, -1, 1'b0);
        tests++;
        if (term !== 4'hE || n_proc != 4 || n_disc != 1) begin
            fails++;
            $display("FAIL tmo4_flow: got term=%h proc=%0d dis=%0d want E 4 1",
                     term, n_proc, n_disc);
        end
        tests++;
        if (c_tmo !== 2'd1 || c_proc !== 2'd0) begin
            fails++;
            $display("FAIL tmo4_counts: got tmo=%0d proc=%0d want 1 0", c_tmo, c_proc);
        end
        tmo = '0;
        run_pkt(1, 1'b0, 500, -1, 1'b0);
        tests++;
        if (term !== 4'h4 || n_proc != 501) begin
            fails++;
            $display("FAIL tmo0_flow: got term=%h proc=%0d want 4 501", term, n_proc);
        end
        tests++;
        if (c_proc !== 2'd1 || c_tmo !== 2'd1) begin
            fails++;
            $display("FAIL tmo0_counts: got proc=%0d tmo=%0d want 1 1", c_proc, c_tmo);
        end
    endtask

    task automatic test_priority();
        clear_stats();
        tmo = TW'(100);
        run_pkt(1, 1'b0, 2, 2, 1'b0);
        tests++;
        if (term !== 4'hC || c_bad !== 2'd1 || c_proc !== 2'd0) begin
            fails++;
            $display("FAIL err_over_done: got term=%h bad=%0d proc=%0d want C 1 0",
                     term, c_bad, c_proc);
        end
        tmo = TW'(4);
        run_pkt(1, 1'b0, 3, -1, 1'b0);
        tests++;
        if (term !== 4'h4 || n_proc != 4 || c_proc !== 2'd1 || c_tmo !== 2'd0) begin
            fails++;
            $display("FAIL done_over_tmo: got term=%h proc_cyc=%0d proc=%0d tmo=%0d want 4 4 1 0",
                     term, n_proc, c_proc, c_tmo);
        end
    endtask

    task automatic test_saturation();
        clear_stats();
        tmo = TW'(100);
        for (int i = 0; i < 5; i++) run_pkt(1, 1'b0, 0, -1, 1'b0);
        tests++;
        if (c_proc !== 2'd3) begin
            fails++;
            $display("FAIL sat_hold: got %0d want 3", c_proc);
        end
        run_pkt(1, 1'b0, 0, -1, 1'b1);
        tests++;
        if (c_proc !== 2'd0 || term !== 4'h4) begin
            fails++;
            $display("FAIL sat_clear_wins: got cnt=%0d term=%h want 0 4", c_proc, term);
        end
    endtask

    task automatic test_reset_mid();
        int nd;
        clear_stats();
        tmo = TW'(100);
        avail = 1'b1;
        fempty = 1'b0;
        tick();
        avail = 1'b0;
        fempty = 1'b1;
        tick();
        tick();
        areset = 1'b1;
        #1;
        tests++;
        if (o_state !== 4'h0 || o_busy !== 1'b0 || o_disc !== 1'b0 || o_start !== 1'b0) begin
            fails++;
            $display("FAIL areset_mid: got state=%h busy=%b dis=%b st=%b want 0 0 0 0",
                     o_state, o_busy, o_disc, o_start);
        end
        tick();
        areset = 1'b0;
        nd = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (o_disc) nd++;
        end
        tests++;
        if (nd != 0 || o_state !== 4'h1) begin
            fails++;
            $display("FAIL areset_no_discard: got dis=%0d state=%h want 0 1", nd, o_state);
        end
        run_pkt(2, 1'b0, 1, -1, 1'b0);
        tests++;
        if (term !== 4'h4 || n_disc != 1 || c_proc !== 2'd1) begin
            fails++;
            $display("FAIL areset_recover: got term=%h dis=%0d proc=%0d want 4 1 1",
                     term, n_disc, c_proc);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_overflow();
        test_timeout();
        test_priority();
        test_saturation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
